// File: rtl/bus_mux_n_if.sv
// Request/response bus bundle for bus_mux_n: N parallel lanes sharing one address/data payload.
// The upstream master side uses N=1; the downstream slave side uses N=N_SLV.
interface bus_mux_n_if #(
    parameter int unsigned N  = 1,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [N-1:0]         req;
    logic [N-1:0]         we;
    logic [DW/8-1:0]      be;
    logic [AW-1:0]        addr;
    logic [DW-1:0]        wdata;
    logic [N-1:0]         gnt;
    logic [N-1:0]         rvalid;
    logic [N-1:0]         err;
    logic [N-1:0][DW-1:0] rdata;

    modport master (output req, we, be, addr, wdata,
                    input  gnt, rvalid, err, rdata);
    modport slave  (input  req, we, be, addr, wdata,
                    output gnt, rvalid, err, rdata);
endinterface

// File: rtl/bus_mux_n.sv
// Address-decoded 1:N bus demultiplexer with in-order response routing FIFO.
// Optional macro BUS_MUX_N_ERR_RESP_EN adds an internal error responder for unmapped addresses.
module bus_mux_n #(
    parameter int unsigned                 N_SLV       = 5,
    parameter int unsigned                 AW          = 32,
    parameter int unsigned                 DW          = 32,
    parameter int unsigned                 MAX_OUTST   = 2,
    parameter logic [N_SLV-1:0][AW-1:0]    SLV_BASE    = '0,
    parameter logic [N_SLV-1:0][AW-1:0]    SLV_SIZE    = {N_SLV{AW'(32'h1000)}},
    parameter int unsigned                 DEFAULT_SLV = 0
) (
    input  logic        Clk,
    input  logic        Rst,
    bus_mux_n_if.slave  m,
    bus_mux_n_if.master s
);

`ifdef BUS_MUX_N_ERR_RESP_EN
    localparam int unsigned N_ID = N_SLV + 1;
`else
    localparam int unsigned N_ID = N_SLV;
`endif
    localparam int unsigned IDW = (N_ID > 1) ? $clog2(N_ID) : 1;
    localparam int unsigned PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CW  = $clog2(MAX_OUTST + 1);

    logic [IDW-1:0]   fifo_q [MAX_OUTST];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [IDW-1:0]   last_id_q;

    logic [IDW-1:0]   tgt;
    logic             dec_hit;
    logic [IDW-1:0]   head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             gate;
    logic             grant;
    logic [N_SLV-1:0] sel;
    logic             rsp_valid;
    logic             rsp_err;
    logic [DW-1:0]    rsp_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef BUS_MUX_N_ERR_RESP_EN
    logic err_pend_q;

    // Responder answers every accepted unmapped request exactly one cycle later.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) err_pend_q <= 1'b0;
        else     err_pend_q <= push && (tgt == IDW'(N_SLV));
    end
`endif

    // Address decode at AW+1 bits so base+size never wraps; lowest index wins.
    always_comb begin
        dec_hit = 1'b0;
        tgt     = IDW'(DEFAULT_SLV);
        for (int i = 0; i < N_SLV; i++) begin
            if (!dec_hit &&
                ({1'b0, m.addr} >= {1'b0, SLV_BASE[i]}) &&
                ({1'b0, m.addr} <  ({1'b0, SLV_BASE[i]} + {1'b0, SLV_SIZE[i]}))) begin
                dec_hit = 1'b1;
                tgt     = IDW'(i);
            end
        end
`ifdef BUS_MUX_N_ERR_RESP_EN
        if (!dec_hit) tgt = IDW'(N_SLV);
`endif
    end

    assign head  = fifo_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(MAX_OUTST));

    // Response path follows the FIFO head; other slaves' rvalid is ignored.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if (!empty) begin
            for (int i = 0; i < N_SLV; i++) begin
                if (head == IDW'(i)) begin
                    rsp_valid = s.rvalid[i];
                    rsp_err   = s.err[i];
                    rsp_data  = s.rdata[i];
                end
            end
`ifdef BUS_MUX_N_ERR_RESP_EN
            if (head == IDW'(N_SLV)) begin
                rsp_valid = err_pend_q;
                rsp_err   = err_pend_q;
            end
`endif
        end
    end

    assign pop = !empty && rsp_valid;

    // An entry retiring this cycle frees its slot for a new issue in the same cycle.
    assign gate = !Rst && (!full || pop) &&
                  (empty || (pop && (count_q == CW'(1))) || (tgt == last_id_q));

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            sel[i] = gate && (tgt == IDW'(i));
        end
    end

    always_comb begin
        grant = m.req[0] && |(sel & s.gnt);
`ifdef BUS_MUX_N_ERR_RESP_EN
        if (m.req[0] && gate && (tgt == IDW'(N_SLV))) grant = 1'b1;
`endif
    end

    assign push = m.req[0] && grant;

    assign s.req   = sel & {N_SLV{m.req[0]}};
    assign s.we    = sel & {N_SLV{m.we[0]}};
    assign s.be    = m.be;
    assign s.addr  = m.addr;
    assign s.wdata = m.wdata;

    assign m.gnt[0]    = grant;
    assign m.rvalid[0] = rsp_valid;
    assign m.err[0]    = rsp_err;
    assign m.rdata[0]  = rsp_data;

    // Routing FIFO: records the target of each granted request, retired in order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_id_q <= '0;
            for (int i = 0; i < MAX_OUTST; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= tgt;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
                last_id_q        <= tgt;
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_bus_mux_n.sv
// Directed bench for bus_mux_n: three slaves at 0x0/0x1000_0000/0x2000_0000, 4 KiB each, MAX_OUTST=2.
module tb_bus_mux_n;
    localparam int unsigned N_SLV = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic Clk;
    logic Rst;
    int   n_cmp;
    int   n_bad;

    bus_mux_n_if #(.N(1),     .AW(AW), .DW(DW)) m_bus ();
    bus_mux_n_if #(.N(N_SLV), .AW(AW), .DW(DW)) s_bus ();

    bus_mux_n #(
        .N_SLV      (N_SLV),
        .AW         (AW),
        .DW         (DW),
        .MAX_OUTST  (2),
        .SLV_BASE   ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_SIZE   ({32'h0000_1000, 32'h0000_1000, 32'h0000_1000}),
        .DEFAULT_SLV(0)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .m  (m_bus),
        .s  (s_bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_bus();
        m_bus.req    = '0;
        m_bus.we     = '0;
        m_bus.be     = '1;
        m_bus.addr   = '0;
        m_bus.wdata  = '0;
        s_bus.gnt    = '1;
        s_bus.rvalid = '0;
        s_bus.err    = '0;
        s_bus.rdata  = '0;
    endtask

    task automatic issue(input logic [31:0] a, input logic w);
        m_bus.req  = 1'b1;
        m_bus.we   = w;
        m_bus.addr = a;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        idle_bus();
        issue(32'h1000_0004, 1'b0);
        s_bus.rvalid   = '1;
        s_bus.rdata[1] = 32'h1234_5678;
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b0)    begin n_bad++; $display("FAIL rst_mgnt: got %b want 0", m_bus.gnt); end
        n_cmp++; if (s_bus.req !== 3'b000)  begin n_bad++; $display("FAIL rst_sreq: got %b want 000", s_bus.req); end
        n_cmp++; if (s_bus.we !== 3'b000)   begin n_bad++; $display("FAIL rst_swe: got %b want 000", s_bus.we); end
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid: got %b want 0", m_bus.rvalid); end
        n_cmp++; if (m_bus.err !== 1'b0)    begin n_bad++; $display("FAIL rst_err: got %b want 0", m_bus.err); end
        n_cmp++; if (m_bus.rdata[0] !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", m_bus.rdata[0]); end
        tick();
        tick();
        idle_bus();
        Rst = 1'b0;
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b0)    begin n_bad++; $display("FAIL post_rst_mgnt: got %b want 0", m_bus.gnt); end
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL post_rst_rvalid: got %b want 0", m_bus.rvalid); end
    endtask

    task automatic test_single_read();
        tick();
        issue(32'h1000_0004, 1'b0);
        m_bus.be    = 4'h6;
        m_bus.wdata = 32'hA5A5_0001;
        #1;
        n_cmp++; if (s_bus.req !== 3'b010)  begin n_bad++; $display("FAIL rd_sreq: got %b want 010", s_bus.req); end
        n_cmp++; if (s_bus.we !== 3'b000)   begin n_bad++; $display("FAIL rd_swe: got %b want 000", s_bus.we); end
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL rd_mgnt: got %b want 1", m_bus.gnt); end
        n_cmp++; if (s_bus.addr !== 32'h1000_0004) begin n_bad++; $display("FAIL rd_saddr: got %h want 10000004", s_bus.addr); end
        n_cmp++; if (s_bus.be !== 4'h6)     begin n_bad++; $display("FAIL rd_sbe: got %h want 6", s_bus.be); end
        n_cmp++; if (s_bus.wdata !== 32'hA5A5_0001) begin n_bad++; $display("FAIL rd_swdata: got %h want a5a50001", s_bus.wdata); end
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_early_rvalid: got %b want 0", m_bus.rvalid); end
        tick();
        idle_bus();
        s_bus.rvalid   = 3'b010;
        s_bus.rdata[1] = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid: got %b want 1", m_bus.rvalid); end
        n_cmp++; if (m_bus.rdata[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_rdata: got %h want deadbeef", m_bus.rdata[0]); end
        n_cmp++; if (m_bus.err !== 1'b0)    begin n_bad++; $display("FAIL rd_err: got %b want 0", m_bus.err); end
        tick();
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_empty_rvalid: got %b want 0", m_bus.rvalid); end
        n_cmp++; if (m_bus.rdata[0] !== 32'h0) begin n_bad++; $display("FAIL rd_empty_rdata: got %h want 0", m_bus.rdata[0]); end
        s_bus.rvalid = '0;
        issue(32'h0000_0010, 1'b1);
        #1;
        n_cmp++; if (s_bus.req !== 3'b001)  begin n_bad++; $display("FAIL wr_sreq: got %b want 001", s_bus.req); end
        n_cmp++; if (s_bus.we !== 3'b001)   begin n_bad++; $display("FAIL wr_swe: got %b want 001", s_bus.we); end
        tick();
        idle_bus();
        s_bus.rvalid = 3'b001;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL wr_rvalid: got %b want 1", m_bus.rvalid); end
        tick();
        s_bus.rvalid = '0;
    endtask

    task automatic test_switch_stall();
        tick();
        issue(32'h0000_0010, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL sw_first_gnt: got %b want 1", m_bus.gnt); end
        tick();
        issue(32'h2000_0000, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b0)    begin n_bad++; $display("FAIL sw_stall_gnt: got %b want 0", m_bus.gnt); end
        n_cmp++; if (s_bus.req !== 3'b000)  begin n_bad++; $display("FAIL sw_stall_sreq: got %b want 000", s_bus.req); end
        tick();
        s_bus.rvalid   = 3'b100;
        s_bus.rdata[2] = 32'hBAD0_0002;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL sw_nonhead_rvalid: got %b want 0", m_bus.rvalid); end
        n_cmp++; if (m_bus.gnt !== 1'b0)    begin n_bad++; $display("FAIL sw_stall2_gnt: got %b want 0", m_bus.gnt); end
        tick();
        s_bus.rvalid   = 3'b001;
        s_bus.rdata[0] = 32'h0000_1111;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL sw_s0_rvalid: got %b want 1", m_bus.rvalid); end
        n_cmp++; if (m_bus.rdata[0] !== 32'h0000_1111) begin n_bad++; $display("FAIL sw_s0_rdata: got %h want 00001111", m_bus.rdata[0]); end
        n_cmp++; if (s_bus.req !== 3'b100)  begin n_bad++; $display("FAIL sw_issue_sreq: got %b want 100", s_bus.req); end
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL sw_issue_gnt: got %b want 1", m_bus.gnt); end
        tick();
        m_bus.req      = 1'b0;
        s_bus.rvalid   = 3'b100;
        s_bus.rdata[2] = 32'h0000_2222;
        #1;
        n_cmp++; if (m_bus.rdata[0] !== 32'h0000_2222) begin n_bad++; $display("FAIL sw_s2_rdata: got %h want 00002222", m_bus.rdata[0]); end
        tick();
        idle_bus();
    endtask

    task automatic test_back_to_back();
        tick();
        issue(32'h2000_0000, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL b2b_gnt1: got %b want 1", m_bus.gnt); end
        tick();
        issue(32'h2000_0004, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL b2b_gnt2: got %b want 1", m_bus.gnt); end
        n_cmp++; if (s_bus.req !== 3'b100)  begin n_bad++; $display("FAIL b2b_sreq2: got %b want 100", s_bus.req); end
        tick();
        issue(32'h2000_0008, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b0)    begin n_bad++; $display("FAIL b2b_full_gnt: got %b want 0", m_bus.gnt); end
        n_cmp++; if (s_bus.req !== 3'b000)  begin n_bad++; $display("FAIL b2b_full_sreq: got %b want 000", s_bus.req); end
        tick();
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b0)    begin n_bad++; $display("FAIL b2b_full2_gnt: got %b want 0", m_bus.gnt); end
        tick();
        s_bus.rvalid   = 3'b100;
        s_bus.rdata[2] = 32'hAAAA_0001;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rv1: got %b want 1", m_bus.rvalid); end
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL b2b_pop_gnt: got %b want 1", m_bus.gnt); end
        tick();
        m_bus.req      = 1'b0;
        s_bus.rdata[2] = 32'hAAAA_0002;
        #1;
        n_cmp++; if (m_bus.rdata[0] !== 32'hAAAA_0002) begin n_bad++; $display("FAIL b2b_rd2: got %h want aaaa0002", m_bus.rdata[0]); end
        tick();
        s_bus.rdata[2] = 32'hAAAA_0003;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rv3: got %b want 1", m_bus.rvalid); end
        n_cmp++; if (m_bus.rdata[0] !== 32'hAAAA_0003) begin n_bad++; $display("FAIL b2b_rd3: got %h want aaaa0003", m_bus.rdata[0]); end
        tick();
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", m_bus.rvalid); end
        idle_bus();
    endtask

    task automatic test_unmapped();
        tick();
        issue(32'h3000_0000, 1'b0);
        s_bus.rdata[0] = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL um_gnt1: got %b want 1", m_bus.gnt); end
`ifdef BUS_MUX_N_ERR_RESP_EN
        n_cmp++; if (s_bus.req !== 3'b000)  begin n_bad++; $display("FAIL um_sreq: got %b want 000", s_bus.req); end
`else
        n_cmp++; if (s_bus.req !== 3'b001)  begin n_bad++; $display("FAIL um_sreq: got %b want 001", s_bus.req); end
`endif
        tick();
        issue(32'h3000_0040, 1'b0);
`ifdef BUS_MUX_N_ERR_RESP_EN
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL um_rv1: got %b want 1", m_bus.rvalid); end
        n_cmp++; if (m_bus.err !== 1'b1)    begin n_bad++; $display("FAIL um_err1: got %b want 1", m_bus.err); end
        n_cmp++; if (m_bus.rdata[0] !== 32'h0) begin n_bad++; $display("FAIL um_rd1: got %h want 0", m_bus.rdata[0]); end
`else
        s_bus.rvalid   = 3'b001;
        s_bus.rdata[0] = 32'h0000_5555;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL um_rv1: got %b want 1", m_bus.rvalid); end
        n_cmp++; if (m_bus.err !== 1'b0)    begin n_bad++; $display("FAIL um_err1: got %b want 0", m_bus.err); end
        n_cmp++; if (m_bus.rdata[0] !== 32'h0000_5555) begin n_bad++; $display("FAIL um_rd1: got %h want 00005555", m_bus.rdata[0]); end
`endif
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL um_gnt2: got %b want 1", m_bus.gnt); end
        tick();
        m_bus.req = 1'b0;
`ifdef BUS_MUX_N_ERR_RESP_EN
        #1;
        n_cmp++; if (m_bus.err !== 1'b1)    begin n_bad++; $display("FAIL um_err2: got %b want 1", m_bus.err); end
`else
        s_bus.rdata[0] = 32'h0000_5556;
        #1;
        n_cmp++; if (m_bus.rdata[0] !== 32'h0000_5556) begin n_bad++; $display("FAIL um_rd2: got %h want 00005556", m_bus.rdata[0]); end
`endif
        n_cmp++; if (m_bus.rvalid !== 1'b1) begin n_bad++; $display("FAIL um_rv2: got %b want 1", m_bus.rvalid); end
        tick();
        s_bus.rvalid = '0;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL um_one_rsp: got %b want 0", m_bus.rvalid); end
        idle_bus();
    endtask

    task automatic test_reset_mid();
        tick();
        issue(32'h1000_0000, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL rm_gnt1: got %b want 1", m_bus.gnt); end
        tick();
        issue(32'h1000_0004, 1'b0);
        #1;
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL rm_gnt2: got %b want 1", m_bus.gnt); end
        tick();
        m_bus.req      = 1'b0;
        Rst            = 1'b1;
        s_bus.rvalid   = 3'b010;
        s_bus.rdata[1] = 32'hBAD0_0001;
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_async_rvalid: got %b want 0", m_bus.rvalid); end
        tick();
        Rst          = 1'b0;
        s_bus.rvalid = '0;
        tick();
        s_bus.rvalid = 3'b010;
        issue(32'h0000_0020, 1'b0);
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_late_rvalid: got %b want 0", m_bus.rvalid); end
        n_cmp++; if (m_bus.rdata[0] !== 32'h0) begin n_bad++; $display("FAIL rm_late_rdata: got %h want 0", m_bus.rdata[0]); end
        n_cmp++; if (m_bus.gnt !== 1'b1)    begin n_bad++; $display("FAIL rm_new_gnt: got %b want 1", m_bus.gnt); end
        n_cmp++; if (s_bus.req !== 3'b001)  begin n_bad++; $display("FAIL rm_new_sreq: got %b want 001", s_bus.req); end
        tick();
        m_bus.req      = 1'b0;
        s_bus.rvalid   = 3'b001;
        s_bus.rdata[0] = 32'h0000_7777;
        #1;
        n_cmp++; if (m_bus.rdata[0] !== 32'h0000_7777) begin n_bad++; $display("FAIL rm_new_rdata: got %h want 00007777", m_bus.rdata[0]); end
        tick();
        idle_bus();
        #1;
        n_cmp++; if (m_bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_idle_rvalid: got %b want 0", m_bus.rvalid); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_read();
        test_switch_stall();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_mux_n.md
BUS_MUX_N -- requirements
Module: bus_mux_n

Interface
REQ-001 SHALL have parameter N_SLV, 5, number of slave ports (1..16).
REQ-002 SHALL have parameter AW, 32, address width.
REQ-003 SHALL have parameter DW, 32, data width.
REQ-004 SHALL have parameter MAX_OUTST, 2, max outstanding transactions (1..8).
REQ-005 SHALL have parameter SLV_BASE, N_SLV x AW packed, per-slave base address.
REQ-006 SHALL have parameter SLV_SIZE, N_SLV x AW packed, per-slave region size in bytes (nonzero).
REQ-007 SHALL have parameter DEFAULT_SLV, 0, slave taking unmapped addresses when error responder is compiled out.
REQ-008 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-009 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-010 SHALL have ports m_req/m_we  input  1/1, m_be  input  DW/8, m_addr  input  AW, m_wdata  input  DW  (master request).
REQ-011 SHALL have ports m_gnt/m_rvalid/m_err  output  1/1/1, m_rdata  output  DW  (master response).
REQ-012 SHALL have ports s_req/s_we  output  N_SLV, s_gnt/s_rvalid/s_err  input  N_SLV, s_rdata  input  N_SLV x DW.
REQ-013 SHALL broadcast m_addr, m_be and m_wdata unmodified to every slave.

Function
REQ-014 Decode: target = lowest index i with SLV_BASE[i] <= m_addr < SLV_BASE[i]+SLV_SIZE[i], computed at AW+1 bits (no wrap); no match = unmapped.
REQ-015 Routing FIFO: depth MAX_OUTST, entries hold target ID (0..N_SLV, N_SLV = error responder); push on m_req & m_gnt, pop on response accepted from head.
REQ-016 Issue gate: request forwarded only if FIFO not full AND (FIFO empty OR target == ID of last pushed entry); otherwise s_req all 0 and m_gnt 0 (stall).
REQ-017 When gate open: s_req[target] = m_req, s_we[target] = m_we, all other s_req/s_we 0; m_gnt = s_gnt[target], combinational.
REQ-018 Response: m_rvalid/m_rdata/m_err = s_rvalid/s_rdata/s_err of head ID; FIFO empty -> m_rvalid 0, m_rdata 0, m_err 0.
REQ-019 s_rvalid from non-head slave SHALL be ignored and not pop the FIFO.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; pop on empty impossible; pointers wrap modulo MAX_OUTST.
REQ-021 Grant latency zero added; response latency zero added (purely routed).

Reset
REQ-022 On Rst high, asynchronously: FIFO occupancy 0, read/write pointers 0, error responder idle.
REQ-023 During and after reset until first request: m_gnt 0, m_rvalid 0, m_err 0, m_rdata 0, s_req 0, s_we 0.
REQ-024 Reset mid-transaction SHALL discard all outstanding entries; late slave rvalid after reset SHALL be ignored.

Configuration
REQ-025 Macro BUS_MUX_N_ERR_RESP_EN defined: unmapped request routed to internal responder with ID N_SLV, granted same cycle (subject to REQ-016), answered exactly 1 cycle later with m_rvalid 1, m_err 1, m_rdata 0; one response per grant, back-to-back supported.
REQ-026 Macro undefined: unmapped address decodes to DEFAULT_SLV; responder logic absent; FIFO ID width covers 0..N_SLV-1 only.

Verification
Bench config: N_SLV=3, MAX_OUTST=2, SLV_BASE={0x0000_0000,0x1000_0000,0x2000_0000}, SLV_SIZE=0x1000 each, slaves with 1-cycle gnt-to-rvalid.
REQ-027 Read 0x1000_0004, slave1 rdata 0xDEAD_BEEF -> only s_req[1] high, m_gnt same cycle, m_rvalid next cycle with 0xDEAD_BEEF, m_err 0.
REQ-028 Read 0x0000_0010 then 0x2000_0000 back-to-back, slave0 response held 3 cycles -> second request stalled (m_gnt 0, s_req 0) until slave0 rvalid, then issued.
REQ-029 Three reads to slave2, slave2 rvalid delayed 4 cycles -> third m_req stalled while occupancy 2; gnt returns same cycle as first pop.
REQ-030 Read 0x3000_0000 with BUS_MUX_N_ERR_RESP_EN -> m_gnt same cycle, next cycle m_rvalid 1, m_err 1, m_rdata 0; without macro -> s_req[0] high.
REQ-031 Rst asserted with 2 outstanding, slave rvalid arrives 1 cycle after release -> m_rvalid stays 0, occupancy 0, next request granted normally.
